// File: rtl/color_cmd_pacer.sv
`default_nettype none
// ============================================================================
// Module   : color_cmd_pacer
// Purpose  : Upstream command stage for the Blue/Red colour FSM. It accepts
//            toggle/hold requests over a valid/ready handshake and queues
//            them in a small FIFO. Each request is issued as a single-cycle
//            code on out_cmd and followed by an enforced idle gap, so the
//            downstream FSM only ever sees isolated commands.
// Ports    : clk        - clock, all logic on the rising edge
//            rst_n      - synchronous reset, active-low
//            req_valid  - request present
//            req_cmd    - 2'h1 toggle, 2'h0 hold, 2'h2/2'h3 illegal
//            req_ready  - FIFO can accept this cycle (combinational)
//            out_cmd    - registered code to the FSM `in` port
//            drop_err   - registered 1-cycle pulse when an illegal code is taken
//            busy       - FIFO non-empty or sequencer not idle (combinational)
//            issued_cnt - [COLOR_CMD_PACER_STATS_EN only] wrapping count of
//                         issued commands
// Options  : define COLOR_CMD_PACER_STATS_EN to add the issued_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module color_cmd_pacer #(
   parameter int         DEPTH     = 4,     // FIFO entries, power of 2, >= 2
   parameter int         GAP       = 3,     // idle cycles after each command
   parameter logic [1:0] IDLE_CODE = 2'h2   // neutral code, not 2'h0 / 2'h1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic [1:0] req_cmd,
   output logic       req_ready,
   output logic [1:0] out_cmd,
   output logic       drop_err,
   output logic       busy
`ifdef COLOR_CMD_PACER_STATS_EN
   ,
   output logic [7:0] issued_cnt
`endif
);

   localparam int              c_AW       = $clog2(DEPTH);
   localparam int              c_CW       = c_AW + 1;
   localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
   // The counter is loaded on leaving ISSUE, so it holds GAP-1 to give
   // exactly GAP cycles in the GAP state.
   localparam logic [7:0]      c_GAP_LOAD = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t          r_state;
   logic [1:0]      r_mem [DEPTH];
   logic [c_AW-1:0] r_wptr;
   logic [c_AW-1:0] r_rptr;
   logic [c_CW-1:0] r_count;
   logic [7:0]      r_gap_cnt;

   logic            w_accept;
   logic            w_illegal;
   logic            w_push;
   logic            w_pop;

   // Readiness depends only on the current fill level: a pop in the same
   // cycle does not free a slot for the incoming request.
   assign req_ready = rst_n && (r_count != c_FULL);
   assign w_accept  = req_valid && req_ready;
   // Codes 2'h2/2'h3 are consumed but never queued.
   assign w_illegal = w_accept && req_cmd[1];
   assign w_push    = w_accept && !req_cmd[1];
   assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
   assign busy      = (r_count != '0) || (r_state != ST_IDLE);

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= req_cmd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_gap_cnt <= '0;
         out_cmd   <= IDLE_CODE;
         drop_err  <= 1'b0;
`ifdef COLOR_CMD_PACER_STATS_EN
         issued_cnt <= '0;
`endif
      end else begin
         drop_err <= w_illegal;

         // Pointers wrap naturally because DEPTH is a power of two.
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  out_cmd <= r_mem[r_rptr];
                  r_state <= ST_ISSUE;
`ifdef COLOR_CMD_PACER_STATS_EN
                  issued_cnt <= issued_cnt + 8'd1;
`endif
               end else begin
                  out_cmd <= IDLE_CODE;
               end
            end

            ST_ISSUE: begin
               // The command is visible for this single cycle only.
               out_cmd <= IDLE_CODE;
               if (GAP == 0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= c_GAP_LOAD;
                  r_state   <= ST_GAP;
               end
            end

            ST_GAP: begin
               out_cmd <= IDLE_CODE;
               if (r_gap_cnt == 8'd0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 8'd1;
               end
            end

            default: begin
               out_cmd <= IDLE_CODE;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_color_cmd_pacer.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_cmd_pacer
// Purpose  : Self-checking bench for color_cmd_pacer (defaults DEPTH=4,
//            GAP=3, IDLE_CODE=2'h2). Legal requests push their expected code
//            into a scoreboard queue; a monitor thread pops and compares
//            whenever out_cmd leaves the idle code. Illegal requests raise an
//            expected drop_err count consumed by the same monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_color_cmd_pacer;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_cmd   = 2'h0;
   logic       req_ready;
   logic [1:0] out_cmd;
   logic       drop_err;
   logic       busy;
`ifdef COLOR_CMD_PACER_STATS_EN
   logic [7:0] issued_cnt;
`endif

   color_cmd_pacer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_cmd   (req_cmd),
      .req_ready (req_ready),
      .out_cmd   (out_cmd),
      .drop_err  (drop_err),
      .busy      (busy)
`ifdef COLOR_CMD_PACER_STATS_EN
      ,
      .issued_cnt(issued_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         checks   = 0;
   int         failures = 0;
   logic [1:0] exp_q[$];
   int         drop_exp = 0;
   int         issue_cyc[$];
   bit         mon_en   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int get_issue(input int i);
      if (i < 0 || i >= issue_cyc.size()) return -1;
      return issue_cyc[i];
   endfunction

   // Scoreboard monitor: any non-idle code must match the queue head.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (out_cmd != 2'h2) begin
               issue_cyc.push_back(cyc);
               if (exp_q.size() == 0) chk("unexpected_cmd", int'(out_cmd), 2);
               else                   chk("cmd_order", int'(out_cmd), int'(exp_q.pop_front()));
            end
            if (drop_err) begin
               if (drop_exp == 0) chk("unexpected_drop", int'(drop_err), 0);
               else               drop_exp--;
            end
         end
      end
   endtask

   // Presents a request at a falling edge and holds it until accepted.
   // Leaves req_valid high so consecutive calls are back-to-back.
   task automatic push(input logic [1:0] c, output int acc);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_cmd   = c;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("push_timeout", n, 0);
         req_valid = 1'b0;
         acc = -1;
         return;
      end
      if (c[1]) drop_exp++;
      else      exp_q.push_back(c);
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_issues(input int target);
      int n = 0;
      while (issue_cyc.size() < target && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("issue_timeout", issue_cyc.size(), target);
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk("drain_timeout", n, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int a;
      int a5;
      int base;
      int last;
      int n;
      fork
         monitor();
      join_none

      // ---------------- reset with a request pending ----------------
      rst_n     = 1'b0;
      req_valid = 1'b1;
      req_cmd   = 2'h1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_ready", int'(req_ready), 0);
         chk("rst_out",   int'(out_cmd),   2);
         chk("rst_busy",  int'(busy),      0);
         chk("rst_drop",  int'(drop_err),  0);
      end
      rst_n     = 1'b1;
      req_valid = 1'b0;
      #1;
      chk("rel_ready", int'(req_ready), 1);
      chk("rel_busy",  int'(busy),      0);
      mon_en = 1'b1;

      // ---------------- single toggle: latency ----------------
      push(2'h1, a);
      idle();
      wait_issues(1);
      chk("latency", get_issue(0), a + 1);
      drain();

      // ---------------- illegal code ----------------
      push(2'h3, a);
      idle();
      repeat (3) @(negedge clk);
      chk("illegal_busy",    int'(busy), 0);
      chk("illegal_noissue", issue_cyc.size(), 1);

      // ---------------- burst to full, then full-with-pop ----------------
      base = issue_cyc.size();
      push(2'h0, a);   // leader keeps the sequencer in its gap
      push(2'h1, a);
      push(2'h0, a);
      push(2'h1, a);
      push(2'h1, a);
      chk("full_ready", int'(req_ready), 0);
      chk("full_busy",  int'(busy),      1);
      push(2'h0, a5);  // blocked until the cycle after the first burst pop
      idle();
      wait_issues(base + 6);
      chk("full_accept", a5, get_issue(base + 1) + 1);
      for (int i = 1; i < 6; i++)
         chk("spacing", get_issue(base + i) - get_issue(base + i - 1), 5);
      last = get_issue(base + 5);
      n = 0;
      while (cyc < last + 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("busy_last_gap", int'(busy), 1);
      @(negedge clk);
      chk("busy_fall", int'(busy), 0);

      // ---------------- reset in the middle of a gap ----------------
      base = issue_cyc.size();
      push(2'h1, a);
      push(2'h0, a);
      push(2'h1, a);
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      exp_q.delete();  // both queued entries must be discarded
      @(negedge clk);
      chk("mrst_out",   int'(out_cmd),   2);
      chk("mrst_busy",  int'(busy),      0);
      chk("mrst_ready", int'(req_ready), 0);
`ifdef COLOR_CMD_PACER_STATS_EN
      chk("mrst_cnt",   int'(issued_cnt), 0);
`endif
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("mrst_discard", issue_cyc.size(), base + 1);
      chk("mrst_idle",    int'(busy), 0);

`ifdef COLOR_CMD_PACER_STATS_EN
      // ---------------- issued_cnt wrap ----------------
      for (int i = 0; i < 10; i++) push(2'(i % 2), a);
      idle();
      drain();
      chk("cnt_10", int'(issued_cnt), 10);
      for (int i = 0; i < 246; i++) push(2'(i % 2), a);
      idle();
      drain();
      chk("cnt_wrap", int'(issued_cnt), 0);
`endif

      drain();
      chk("exp_q_empty", exp_q.size(), 0);
      chk("drop_all",    drop_exp,     0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
